// File: rtl/weight_update_unit.sv
// weight_update_unit: applies a stream of float change words to one layer's weight RAM (w += change)
module weight_update_unit #(
  parameter int MAXWEIGHTS = 784,
  parameter int MAXRESULTS = 15,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       n_inputs,
  input  logic [31:0]       n_neurons,
  input  logic [31:0]       change_data,
  input  logic              change_valid,
  output logic              change_ready,
  output logic [ADDR_W-1:0] wmem_addr,
  output logic              wmem_rd_en,
  input  logic [31:0]       wmem_rd_data,
  output logic              wmem_wr_en,
  output logic [31:0]       wmem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf_err,
  output logic [31:0]       upd_count
);
  typedef enum logic [2:0] {IDLE, FETCH, ADD, WRITE, DONE} state_t;
  state_t state;
  logic [31:0] lim_w, lim_n, w_idx, n_idx, chg, nw, nn, sum;
  logic [ADDR_W-1:0] addr, base;
  // IEEE-754 single add, round-to-nearest-even; subnormal inputs and results flush to zero
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [26:0] ma, mb;
    logic [27:0] s;
    logic [7:0] d;
    logic signed [9:0] e;
    logic [24:0] r;
    logic xn, yn;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      if (xn || yn || (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31])) return 32'h7FC00000;
      return (x[30:23] == 8'hFF) ? x : y;
    end
    a = (x[30:0] >= y[30:0]) ? x : y;
    b = (x[30:0] >= y[30:0]) ? y : x;
    ma = (a[30:23] != 0) ? {1'b1, a[22:0], 3'b0} : '0;
    mb = (b[30:23] != 0) ? {1'b1, b[22:0], 3'b0} : '0;
    d = a[30:23] - b[30:23];
    mb = (d > 8'd26) ? {26'b0, |mb} : ((mb >> d) | {26'b0, |(mb & ~({27{1'b1}} << d))});
    e = $signed({2'b0, a[30:23]});
    if (a[31] == b[31]) begin
      s = {1'b0, ma} + {1'b0, mb};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, ma - mb};
    end
    if (s == 0) return {a[31] & b[31], 31'b0};
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    r = {1'b0, s[26:3]} + {24'b0, s[2] & (s[1] | s[0] | s[3])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {a[31], 8'hFF, 23'b0};
    if (e <= 10'sd0) return {a[31], 31'b0};
    return {a[31], e[7:0], r[22:0]};
  endfunction
  always_comb begin
    nw = (n_inputs > 32'(MAXWEIGHTS)) ? 32'(MAXWEIGHTS) : n_inputs;
    nn = (n_neurons > 32'(MAXRESULTS)) ? 32'(MAXRESULTS) : n_neurons;
    sum = fadd(wmem_rd_data, chg);
  end
  assign change_ready = (state == FETCH);
  assign wmem_rd_en = change_ready & change_valid;
  assign wmem_wr_en = (state == WRITE);
  assign busy = (state == FETCH) || (state == ADD) || (state == WRITE);
  assign done = (state == DONE);
  assign wmem_addr = addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lim_w <= '0;
      lim_n <= '0;
      w_idx <= '0;
      n_idx <= '0;
      chg <= '0;
      addr <= '0;
      base <= '0;
      wmem_wr_data <= '0;
      ovf_err <= 1'b0;
      upd_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          lim_w <= nw;
          lim_n <= nn;
          w_idx <= '0;
          n_idx <= '0;
          addr <= '0;
          base <= '0;
          upd_count <= '0;
          ovf_err <= 1'b0;
          state <= (nw == 0 || nn == 0) ? DONE : FETCH;
        end
        FETCH: if (change_valid) begin
          chg <= change_data;
          state <= ADD;
        end
        ADD: begin
          // an Inf/NaN sum would poison the weight, so the old value is kept and the error flagged
          wmem_wr_data <= (sum[30:23] == 8'hFF) ? wmem_rd_data : sum;
          if (sum[30:23] == 8'hFF) ovf_err <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          upd_count <= upd_count + 1;
          if (w_idx == lim_w - 1 && n_idx == lim_n - 1) begin
            state <= DONE;
          end else if (w_idx == lim_w - 1) begin
            w_idx <= '0;
            n_idx <= n_idx + 1;
            base <= base + ADDR_W'(MAXWEIGHTS);
            addr <= base + ADDR_W'(MAXWEIGHTS);
            state <= FETCH;
          end else begin
            w_idx <= w_idx + 1;
            addr <= addr + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_update_unit.sv
// tb_weight_update_unit: scoreboard bench for weight_update_unit with a behavioural weight RAM
module tb_weight_update_unit;
  logic clk = 0, rst = 1, start = 0, change_valid = 0, change_ready;
  logic [31:0] n_inputs = 0, n_neurons = 0, change_data = 0;
  logic [13:0] wmem_addr;
  logic wmem_rd_en, wmem_wr_en, busy, done, ovf_err;
  logic [31:0] wmem_rd_data, wmem_wr_data, upd_count;
  logic [31:0] mem [0:16383];
  logic fill = 0;
  logic [31:0] fill_val = 0;
  logic [63:0] sb [$];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  weight_update_unit dut (
    .clk(clk), .rst(rst), .start(start), .n_inputs(n_inputs), .n_neurons(n_neurons),
    .change_data(change_data), .change_valid(change_valid), .change_ready(change_ready),
    .wmem_addr(wmem_addr), .wmem_rd_en(wmem_rd_en), .wmem_rd_data(wmem_rd_data),
    .wmem_wr_en(wmem_wr_en), .wmem_wr_data(wmem_wr_data), .busy(busy), .done(done),
    .ovf_err(ovf_err), .upd_count(upd_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) for (int i = 0; i < 16384; i++) mem[i] <= fill_val;
    if (wmem_rd_en) wmem_rd_data <= mem[wmem_addr];
    if (wmem_wr_en) mem[wmem_addr] <= wmem_wr_data;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (wmem_rd_en && wmem_wr_en) check("rd_wr_overlap", 1, 0);
      if (change_ready && !change_valid && wmem_rd_en) check("wait_rd", 1, 0);
      if (wmem_wr_en) begin
        if (sb.size() == 0) check("wr_unexpected", {50'b0, wmem_addr}, 64'hFFFF);
        else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("wr_addr", {50'b0, wmem_addr}, {32'b0, e[63:32]});
          check("wr_data", {32'b0, wmem_wr_data}, {32'b0, e[31:0]});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic load_ram(input logic [31:0] v);
    @(negedge clk);
    fill_val = v;
    fill = 1;
    @(negedge clk);
    fill = 0;
  endtask
  // abort: index of the word whose ADD cycle gets hit by reset (-1 for none)
  task automatic run_update(input int ni, input int nn, input logic [31:0] chg, input logic [31:0] exp,
                            input int gap, input int abort, input logic exp_ovf);
    int lw, ln, total, d0, st, t;
    lw = (ni > 784) ? 784 : ni;
    ln = (nn > 15) ? 15 : nn;
    total = lw * ln;
    d0 = done_cnt;
    @(negedge clk);
    n_inputs = ni;
    n_neurons = nn;
    start = 1;
    st = cyc;
    @(negedge clk);
    start = 0;
    if (total > 0) begin
      check("busy_run", {63'b0, busy}, 1);
      check("ovf_clear", {63'b0, ovf_err}, 0);
      check("cnt_clear", {32'b0, upd_count}, 0);
    end
    for (int k = 0; k < total; k++) begin
      t = 0;
      while (!change_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!change_ready) begin
        check("ready_timeout", 0, 1);
        return;
      end
      repeat (gap) @(negedge clk);
      change_valid = 1;
      change_data = chg;
      if (k != abort) sb.push_back({32'((k / lw) * 784 + (k % lw)), exp});
      @(negedge clk);
      change_valid = 0;
      if (k == abort) begin
        rst = 1;
        @(negedge clk);
        check("rst_outs", {change_ready, wmem_rd_en, wmem_wr_en, busy, done, ovf_err, 18'b0, wmem_addr},
              64'h0);
        check("rst_data", {wmem_wr_data, upd_count}, 64'h0);
        rst = 0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 64'(done_cnt), 64'(d0));
        check("rst_sb_empty", 64'(sb.size()), 0);
        sb.delete();
        return;
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt - d0), 1);
    check("done_latency", 64'(done_cyc - st), 64'(3 * total + 1 + gap * total));
    repeat (4) @(negedge clk);
    check("one_done", 64'(done_cnt - d0), 1);
    check("upd_count", {32'b0, upd_count}, 64'(total));
    check("ovf_err", {63'b0, ovf_err}, {63'b0, exp_ovf});
    check("busy_idle", {63'b0, busy}, 0);
    check("sb_empty", 64'(sb.size()), 0);
    sb.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {change_ready, wmem_rd_en, wmem_wr_en, busy, done, ovf_err, 18'b0, wmem_addr}, 64'h0);
    check("reset_data", {wmem_wr_data, upd_count}, 64'h0);
    rst = 0;
    load_ram(32'h3F800000);
    run_update(3, 2, 32'h3F000000, 32'h3FC00000, 0, -1, 0);
    load_ram(32'h3F800000);
    run_update(3, 2, 32'h3F000000, 32'h3FC00000, 5, -1, 0);
    load_ram(32'h3F800000);
    run_update(2, 1, 32'hBF400000, 32'h3E800000, 0, -1, 0);
    load_ram(32'h7F7FFFFF);
    run_update(2, 1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, -1, 1);
    repeat (10) @(negedge clk);
    check("ovf_sticky", {63'b0, ovf_err}, 1);
    run_update(4, 0, 32'h3F000000, 32'h0, 0, -1, 0);
    load_ram(32'h3F800000);
    run_update(1000, 1, 32'h3F000000, 32'h3FC00000, 0, -1, 0);
    load_ram(32'h3F800000);
    run_update(3, 2, 32'h3F000000, 32'h3FC00000, 0, 3, 0);
    load_ram(32'h3F800000);
    run_update(3, 2, 32'h3F000000, 32'h3FC00000, 0, -1, 0);
    load_ram(32'h3F800000);
    fork
      run_update(3, 2, 32'h3F000000, 32'h3FC00000, 0, -1, 0);
      begin
        int t = 0;
        @(negedge clk);
        @(negedge clk);
        while (!wmem_wr_en && t < 100) begin
          @(negedge clk);
          t++;
        end
        n_inputs = 5;
        n_neurons = 5;
        start = 1;
        @(negedge clk);
        start = 0;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
